// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and sizing helpers for the systolic sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_SWITCH,
        S_STREAM,
        S_DONE
    } seq_state_t;

    // Index width for an N-entry row select; a 1-row array still gets a 1-bit port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Input-stream phase length: vectors plus the skew fill and drain of both edges.
    function automatic int unsigned stream_len(input int unsigned n, input int unsigned nv);
        return nv + 2 * n - 2;
    endfunction

endpackage

// File: rtl/skew_shift.sv
// rtl/skew_shift.sv - row-skew delay line; dout[k] is din delayed k+1 cycles
module skew_shift #(
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              din,
    output logic [STAGES-1:0] dout
);

    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (clr) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - weight-load / bank-switch / input-stream sequencer for an N x N systolic array
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N        = 2,
    parameter int VEC_W    = 16,
    localparam int IDX_W   = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] num_vecs,
    input  logic [N-1:0]     col_en,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     pe_enabled,
    output logic             w_accept,
    output logic [IDX_W-1:0] w_row_idx,
    output logic             pe_switch,
    output logic [N-1:0]     in_valid,
    output logic [VEC_W-1:0] vec_idx
);

    localparam int CNT_W = VEC_W + $clog2(2 * N) + 1;

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] nv_q, nv_d;
    logic [N-1:0]     col_q, col_d;
    logic [CNT_W-1:0] t_last;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     pe_en_q, pe_en_d;
    logic             w_acc_q, w_acc_d;
    logic [IDX_W-1:0] w_row_q, w_row_d;
    logic             pe_sw_q, pe_sw_d;
    logic             iv0_q, iv0_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             row0_active;

    assign t_last = CNT_W'(stream_len(N, 32'(nv_q))) - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nv_d    = num_vecs;
                    col_d   = col_en;
                    cnt_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SWITCH: begin
                cnt_d   = '0;
                state_d = (nv_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (cnt_q == t_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            nv_d    = '0;
            col_d   = '0;
        end
    end

    // Outputs are decoded from the next state and flopped, so they line up with the state they describe.
    always_comb begin
        row0_active = cnt_d < CNT_W'(nv_d);
        busy_d      = (state_d == S_LOAD_W) || (state_d == S_SWITCH) || (state_d == S_STREAM);
        done_d      = (state_d == S_DONE);
        pe_en_d     = (state_d == S_IDLE) ? '0 : col_d;
        w_acc_d     = (state_d == S_LOAD_W);
        w_row_d     = w_acc_d ? cnt_d[IDX_W-1:0] : '0;
        pe_sw_d     = (state_d == S_SWITCH);
        iv0_d       = (state_d == S_STREAM) && row0_active;
        vec_d       = '0;
        if (state_d == S_STREAM) begin
            vec_d = row0_active ? cnt_d[VEC_W-1:0] : nv_d - VEC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pe_en_q <= '0;
            w_acc_q <= 1'b0;
            w_row_q <= '0;
            pe_sw_q <= 1'b0;
            iv0_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pe_en_q <= pe_en_d;
            w_acc_q <= w_acc_d;
            w_row_q <= w_row_d;
            pe_sw_q <= pe_sw_d;
            iv0_q   <= iv0_d;
            vec_q   <= vec_d;
        end
    end

    generate
        if (N > 1) begin : g_skew
            logic [N-2:0] skew_out;
            skew_shift #(
                .STAGES (N - 1)
            ) u_skew (
                .clk  (clk),
                .rst  (rst),
                .clr  (abort),
                .din  (iv0_q),
                .dout (skew_out)
            );
            assign in_valid = {skew_out, iv0_q};
        end else begin : g_no_skew
            assign in_valid = iv0_q;
        end
    endgenerate

    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_enabled = pe_en_q;
    assign w_accept   = w_acc_q;
    assign w_row_idx  = w_row_q;
    assign pe_switch  = pe_sw_q;
    assign vec_idx    = vec_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed table-driven bench for systolic_seq_ctrl (N=2 and N=4 instances)
module tb_systolic_seq_ctrl;

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] nv;
        logic [1:0]  col;
        logic        busy;
        logic        done;
        logic        wacc;
        logic        widx;
        logic        sw;
        logic [1:0]  inv;
        logic [15:0] vidx;
        logic        chkv;
        logic [1:0]  pe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [15:0] nv2 = '0;
    logic [1:0]  col2 = '0;
    logic        busy2, done2, wacc2, sw2;
    logic [1:0]  pe2, inv2;
    logic [0:0]  widx2;
    logic [15:0] vidx2;

    logic        start4 = 1'b0, abort4 = 1'b0;
    logic [15:0] nv4 = '0;
    logic [3:0]  col4 = '0;
    logic        busy4, done4, wacc4, sw4;
    logic [3:0]  pe4, inv4;
    logic [1:0]  widx4;
    logic [15:0] vidx4;

    int total = 0;
    int bad   = 0;

    vec_t t1 [11];
    vec_t vq [$];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(2), .VEC_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .num_vecs(nv2), .col_en(col2), .busy(busy2), .done(done2),
        .pe_enabled(pe2), .w_accept(wacc2), .w_row_idx(widx2),
        .pe_switch(sw2), .in_valid(inv2), .vec_idx(vidx2)
    );

    systolic_seq_ctrl #(.N(4), .VEC_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .num_vecs(nv4), .col_en(col4), .busy(busy4), .done(done4),
        .pe_enabled(pe4), .w_accept(wacc4), .w_row_idx(widx4),
        .pe_switch(sw4), .in_valid(inv4), .vec_idx(vidx4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic ab, input logic [15:0] nv,
                                input logic [1:0] col, input logic b, input logic d,
                                input logic wa, input logic wi, input logic s,
                                input logic [1:0] iv, input logic [15:0] vi,
                                input logic cv, input logic [1:0] pe);
        vec_t v;
        v.start = st; v.abort = ab; v.nv = nv; v.col = col;
        v.busy = b; v.done = d; v.wacc = wa; v.widx = wi; v.sw = s;
        v.inv = iv; v.vidx = vi; v.chkv = cv; v.pe = pe;
        return v;
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vq[k]) begin
            @(negedge clk);
            chk($sformatf("%s[%0d].busy", tag, k), 32'(busy2), 32'(vq[k].busy));
            chk($sformatf("%s[%0d].done", tag, k), 32'(done2), 32'(vq[k].done));
            chk($sformatf("%s[%0d].w_accept", tag, k), 32'(wacc2), 32'(vq[k].wacc));
            chk($sformatf("%s[%0d].w_row_idx", tag, k), 32'(widx2), 32'(vq[k].widx));
            chk($sformatf("%s[%0d].pe_switch", tag, k), 32'(sw2), 32'(vq[k].sw));
            chk($sformatf("%s[%0d].in_valid", tag, k), 32'(inv2), 32'(vq[k].inv));
            chk($sformatf("%s[%0d].pe_enabled", tag, k), 32'(pe2), 32'(vq[k].pe));
            if (vq[k].chkv) begin
                chk($sformatf("%s[%0d].vec_idx", tag, k), 32'(vidx2), 32'(vq[k].vidx));
            end
            start2 = vq[k].start;
            abort2 = vq[k].abort;
            nv2    = vq[k].nv;
            col2   = vq[k].col;
        end
        vq.delete();
    endtask

    task automatic chk_all_zero2(input string tag);
        chk({tag, ".busy"}, 32'(busy2), 0);
        chk({tag, ".done"}, 32'(done2), 0);
        chk({tag, ".w_accept"}, 32'(wacc2), 0);
        chk({tag, ".w_row_idx"}, 32'(widx2), 0);
        chk({tag, ".pe_switch"}, 32'(sw2), 0);
        chk({tag, ".in_valid"}, 32'(inv2), 0);
        chk({tag, ".pe_enabled"}, 32'(pe2), 0);
        chk({tag, ".vec_idx"}, 32'(vidx2), 0);
    endtask

    initial begin
        // T1 reference trace: start with num_vecs=3, col_en=10; later cycles drive junk to prove latching.
        t1[0]  = mk(1, 0, 3, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
        t1[1]  = mk(0, 0, 7, 2'b01, 1, 0, 1, 0, 0, 2'b00, 0, 0, 2'b10);
        t1[2]  = mk(0, 0, 7, 2'b01, 1, 0, 1, 1, 0, 2'b00, 0, 0, 2'b10);
        t1[3]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 1, 2'b00, 0, 0, 2'b10);
        t1[4]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 2'b01, 0, 1, 2'b10);
        t1[5]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 2'b11, 1, 1, 2'b10);
        t1[6]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 2'b11, 2, 1, 2'b10);
        t1[7]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 2'b10, 2, 1, 2'b10);
        t1[8]  = mk(0, 0, 7, 2'b01, 1, 0, 0, 0, 0, 2'b00, 2, 1, 2'b10);
        t1[9]  = mk(0, 0, 7, 2'b01, 0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b10);
        t1[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);

        #3;
        chk_all_zero2("reset");
        chk("reset.busy4", 32'(busy4), 0);
        chk("reset.in_valid4", 32'(inv4), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1
        foreach (t1[k]) vq.push_back(t1[k]);
        run_vecs("T1");

        // T2: zero-vector job skips STREAM
        vq.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00));
        vq.push_back(mk(0, 0, 5, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 1, 2'b11));
        vq.push_back(mk(0, 0, 5, 2'b00, 1, 0, 1, 1, 0, 2'b00, 0, 1, 2'b11));
        vq.push_back(mk(0, 0, 5, 2'b00, 1, 0, 0, 0, 1, 2'b00, 0, 1, 2'b11));
        vq.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 1, 2'b11));
        vq.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00));
        run_vecs("T2");

        // T3: abort in cycle 5, all-zero cycle 6, fresh start in cycle 7
        for (int k = 0; k <= 5; k++) vq.push_back(t1[k]);
        vq[5].abort = 1'b1;
        vq[5].start = 1'b1;
        vq.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00));
        foreach (t1[k]) vq.push_back(t1[k]);
        run_vecs("T3");

        // T4: start pulses at 2 and 6 ignored, start at 10 begins a new job
        foreach (t1[k]) vq.push_back(t1[k]);
        vq[2].start = 1'b1;
        vq[6].start = 1'b1; vq[6].nv = 1; vq[6].col = 2'b11;
        vq[10].start = 1'b1; vq[10].nv = 3; vq[10].col = 2'b10;
        for (int k = 1; k <= 10; k++) vq.push_back(t1[k]);
        run_vecs("T4");

        // T5: asynchronous reset in the middle of STREAM
        for (int k = 0; k <= 5; k++) vq.push_back(t1[k]);
        run_vecs("T5a");
        #2;
        chk("T5.pre_rst_busy", 32'(busy2), 1);
        rst = 1'b1;
        #1;
        chk_all_zero2("T5.async");
        @(negedge clk);
        chk_all_zero2("T5.held");
        rst = 1'b0;
        foreach (t1[k]) vq.push_back(t1[k]);
        run_vecs("T5b");

        // T6: N=4, num_vecs=5, col_en=0111
        for (int c = 0; c < 20; c++) begin
            int   t;
            logic strm;
            logic [3:0] e_inv;
            @(negedge clk);
            t    = c - 6;
            strm = (c >= 6) && (c <= 16);
            for (int i = 0; i < 4; i++) begin
                e_inv[i] = strm && (t >= i) && (t < i + 5);
            end
            chk($sformatf("T6[%0d].busy", c), 32'(busy4), 32'((c >= 1) && (c <= 16)));
            chk($sformatf("T6[%0d].done", c), 32'(done4), 32'(c == 17));
            chk($sformatf("T6[%0d].w_accept", c), 32'(wacc4), 32'((c >= 1) && (c <= 4)));
            chk($sformatf("T6[%0d].w_row_idx", c), 32'(widx4), ((c >= 1) && (c <= 4)) ? 32'(c - 1) : 0);
            chk($sformatf("T6[%0d].pe_switch", c), 32'(sw4), 32'(c == 5));
            chk($sformatf("T6[%0d].pe_enabled", c), 32'(pe4), ((c >= 1) && (c <= 17)) ? 32'h7 : 0);
            chk($sformatf("T6[%0d].in_valid", c), 32'(inv4), 32'(e_inv));
            if (strm) begin
                chk($sformatf("T6[%0d].vec_idx", c), 32'(vidx4), (t < 5) ? 32'(t) : 32'd4);
            end
            start4 = (c == 0);
            nv4    = (c == 0) ? 16'd5 : 16'd9;
            col4   = (c == 0) ? 4'b0111 : 4'b1000;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
